// File: rtl/seq_detector_param.sv
// Runtime-configurable serial bit-pattern detector: programmable pattern/length,
// overlap or non-overlap matching, input qualifier, registered pulse, saturating count.
module seq_detector_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 16,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0000_1011,
    parameter int                 DEF_LEN     = 4,
    parameter bit                 DEF_OVERLAP = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           x_valid,
    input  logic                           x,
    input  logic                           cfg_load,
    input  logic [MAX_LEN-1:0]             cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
    input  logic                           cfg_overlap,
    input  logic                           cnt_clr,
    output logic                           y,
    output logic [CNT_W-1:0]               match_cnt,
    output logic                           cfg_err
);
    localparam int               LEN_W    = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] MAX_FILL = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [MAX_LEN-1:0] hist_r;
    logic [LEN_W-1:0]   fill_r;
    logic [MAX_LEN-1:0] pattern_r;
    logic [LEN_W-1:0]   len_r;
    logic               overlap_r;
    logic               y_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               cfg_err_r;

    logic               accept_s;
    logic [MAX_LEN-1:0] cand_s;
    logic [MAX_LEN-1:0] mask_s;
    logic               eligible_s;
    logic               hit_s;
    logic [LEN_W-1:0]   fill_inc_s;
    logic               cfg_ok_s;
    logic [CNT_W-1:0]   cnt_next_s;

    // Match evaluation: only the low len bits of the shifted-in window are compared.
    always_comb begin
        accept_s   = x_valid & ~cfg_load;
        cand_s     = {hist_r[MAX_LEN-2:0], x};
        mask_s     = {MAX_LEN{1'b0}};
        for (int i = 0; i < MAX_LEN; i++) begin
            mask_s[i] = (LEN_W'(i) < len_r);
        end
        eligible_s = ({1'b0, fill_r} + {1'b0, LEN_ONE}) >= {1'b0, len_r};
        hit_s      = accept_s && eligible_s &&
                     (((cand_s ^ pattern_r) & mask_s) == {MAX_LEN{1'b0}});
        fill_inc_s = (fill_r == MAX_FILL) ? fill_r : (fill_r + LEN_ONE);
        cfg_ok_s   = (cfg_len != {LEN_W{1'b0}}) && (cfg_len <= MAX_FILL);
    end

    // Next match count: a clear wins, but a coincident hit still counts as one.
    always_comb begin
        cnt_next_s = cnt_r;
        if (cnt_clr) begin
            cnt_next_s = hit_s ? CNT_ONE : {CNT_W{1'b0}};
        end else if (hit_s && (cnt_r != CNT_MAX)) begin
            cnt_next_s = cnt_r + CNT_ONE;
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Configuration and bit history; a load takes priority over a presented bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_r <= DEF_PATTERN;
            len_r     <= LEN_W'(DEF_LEN);
            overlap_r <= DEF_OVERLAP;
            hist_r    <= {MAX_LEN{1'b0}};
            fill_r    <= {LEN_W{1'b0}};
        end else if (cfg_load) begin
            if (cfg_ok_s) begin
                pattern_r <= cfg_pattern;
                len_r     <= cfg_len;
                overlap_r <= cfg_overlap;
                hist_r    <= {MAX_LEN{1'b0}};
                fill_r    <= {LEN_W{1'b0}};
            end
        end else if (accept_s) begin
            hist_r <= cand_s;
            fill_r <= (hit_s && !overlap_r) ? {LEN_W{1'b0}} : fill_inc_s;
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_r       <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            cfg_err_r <= 1'b0;
        end else begin
            y_r       <= hit_s;
            cnt_r     <= cnt_next_s;
            cfg_err_r <= cfg_load & ~cfg_ok_s;
        end
    end

    assign y         = y_r;
    assign match_cnt = cnt_r;
    assign cfg_err   = cfg_err_r;

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised, runtime-configurable serial bit-pattern detector. Successor to the fixed 4-bit "1011" non-overlapping detector.
- Adds the following:
  - programmable pattern and length up to MAX_LEN;
  - overlap or non-overlap mode;
  - an input-valid qualifier;
  - a registered match pulse;
  - a saturating match counter.
- Sits on serial bitstream paths; feeds event/status logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- CNT_W, 16, match counter width.
- DEF_PATTERN, 8'b0000_1011, pattern loaded at reset (MAX_LEN bits wide).
- DEF_LEN, 4, pattern length at reset (1..MAX_LEN).
- DEF_OVERLAP, 0, mode at reset (0 = non-overlap, 1 = overlap).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- x_valid, input, 1, x is sampled this cycle.
- x, input, 1, serial data bit.
- cfg_load, input, 1, load the cfg_* fields this cycle.
- cfg_pattern, input, MAX_LEN, pattern; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len, input, $clog2(MAX_LEN+1), pattern length.
- cfg_overlap, input, 1, mode select.
- cnt_clr, input, 1, synchronous clear of match_cnt.
- y, output, 1, registered one-cycle match pulse.
- match_cnt, output, CNT_W, saturating count of matches.
- cfg_err, output, 1, one-cycle pulse when a load is rejected.

Behaviour:
- Reset (rst_n low, asynchronous):
  - hist = 0, fill = 0.
  - pattern/len/overlap take their DEF_* values.
  - y = 0, match_cnt = 0, cfg_err = 0.
  - All take effect immediately, including mid-stream.
- Internal state:
  - hist: MAX_LEN-bit shift register of accepted bits, newest in bit 0.
  - fill: 0..MAX_LEN, count of bits eligible for matching; saturates at MAX_LEN.
- Accepted bit (x_valid=1, cfg_load=0):
  - hist <= {hist[MAX_LEN-2:0], x}.
  - win = {hist[len-2:0], x} (for len=1, win = x).
  - hit = (fill+1 >= len) && (win == pattern[len-1:0]).
- On hit:
  - y <= 1; match_cnt increments, saturating at all-ones.
  - Non-overlap mode: fill <= 0, so the next match needs len fresh bits.
  - Overlap mode: fill <= min(fill+1, MAX_LEN).
- No hit: y <= 0; fill <= min(fill+1, MAX_LEN).
- x_valid=0: hist and fill hold; y <= 0.
- Latency: y is high exactly in the cycle after the edge that sampled the final pattern bit. Never high for two consecutive cycles unless two consecutive accepted bits both hit.
- cfg_load:
  - Priority over x_valid; a bit presented in the same cycle is discarded.
  - Legal load (1 <= cfg_len <= MAX_LEN): pattern, len and overlap update; hist and fill clear to 0; y <= 0; match_cnt unchanged.
  - Illegal load (cfg_len = 0 or > MAX_LEN): configuration is unchanged, hist and fill are untouched, and cfg_err <= 1 for one cycle.
- cnt_clr:
  - match_cnt <= 0.
  - If cnt_clr and a hit occur in the same cycle, match_cnt <= 1.
- len=1: every accepted bit equal to pattern[0] hits, in both modes.
- Pattern bits above len-1 are ignored.

Test Plan:
1. Reset defaults (1011, non-overlap); stream 1,0,1,1,0,1,1 on consecutive cycles -> y pulses once, in the cycle after bit 4; match_cnt=1.
2. Load cfg_overlap=1 with pattern 1011, len 4; same stream -> y pulses after bits 4 and 7; match_cnt=2.
3. Repeat scenario 1 with 1-3 idle cycles (x_valid=0) between bits -> identical hit positions counted in accepted bits; y is 0 on all idle cycles.
4. Load pattern 3'b110, len 3, non-overlap; stream 1,1,0,1,1,0 -> y after bits 3 and 6. Then load with cfg_len=0 -> cfg_err pulses once and the 110 detection is unchanged.
5. Mid-sequence reload:
   - Stream 1,0,1, then cfg_load (same config) with x_valid=1, x=1 in that cycle -> that bit is dropped and there is no match.
   - Then 1,0,1,1 -> match after the 4th new bit.
6. Counter and reset edge cases:
   - CNT_W=2 with 5 matches -> match_cnt=3 (saturated).
   - cnt_clr coincident with a hit -> match_cnt=1.
   - Assert rst_n low asynchronously mid-stream (between clock edges) while y=1 -> y and match_cnt drop to 0 immediately.
